serial_pass_tx: RTL
===================

Name: serial_pass_tx

Overview:
- Serial password/pattern transmitter. It is the sending end of the serial link used by the team's Moore "101" pass detector.
- Loads a programmable bit pattern of up to MAX_LEN bits and shifts it out MSB-first on a one-bit serial line.
- Features: programmable bit period, repeat count and inter-frame gap, start/ready handshake, abort input.
- Bench and SoC use: drives the detector's x input.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits.
- LEN_W, 4, width of len input; must satisfy 2^LEN_W > MAX_LEN.
- DIV_W, 8, width of bit-period divider.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to transmit; sampled only when ready=1.
- abort  input  1  synchronous abort of the current transmission.
- pattern  input  MAX_LEN  bits to send; only bits [len-1:0] are used.
- len  input  LEN_W  number of bits per frame; values above MAX_LEN are clamped to MAX_LEN.
- repeat_n  input  4  extra frames; total frames = repeat_n+1.
- gap  input  4  idle clocks between frames.
- bit_div  input  DIV_W  clocks per bit; 0 is treated as 1.
- ready  output  1  high in IDLE; low while busy.
- x_out  output  1  serial data, registered; 0 when not sending.
- x_valid  output  1  high on every clock x_out carries a pattern bit.
- done  output  1  one-cycle pulse at completion of the last frame.

Behaviour:
- Reset: rst_n low → state IDLE, x_out=0, x_valid=0, done=0, ready=1, all counters 0. Effect is immediate, including mid-transmission.
- State machine: IDLE, SEND, GAP.
- IDLE:
  - ready=1.
  - start=1 at edge k: capture pattern, clamped len, repeat_n, gap and effective bit_div into internal registers; later input changes have no effect.
  - Capture with len≥1: enter SEND. First bit (pattern[len-1]) appears on x_out with x_valid=1 in the cycle after edge k.
  - Capture with len=0: stay in IDLE, pulse done=1 in the cycle after edge k, x_valid never asserts.
- SEND:
  - Each bit is held for bit_div clocks (min 1). Order: bit index len-1 down to 0.
  - After the final clock of bit 0, one of three branches applies:
    - frames remaining and gap>0: enter GAP.
    - frames remaining and gap=0: start the next frame on the next clock (back-to-back, no idle cycle).
    - no frames remaining: enter IDLE and pulse done=1 in the first IDLE cycle.
- GAP: x_out=0, x_valid=0 for exactly gap clocks, then SEND restarts at bit len-1.
- ready=0 in SEND and GAP.
- start while not ready is ignored; requests are not queued.
- done cycle: ready=1 in that cycle. A start in that cycle is accepted and the new frame begins on the next clock.
- abort=1 in SEND or GAP: next edge goes to IDLE with x_out=0, x_valid=0 and no done pulse. abort in IDLE has no effect.
- abort and start in the same cycle while in IDLE: start wins.
- Latency for one frame with bit_div=D and length L:
  - first bit at k+1.
  - last bit ends at k+L·D.
  - done at k+L·D+1.
- Counters:
  - bit index LEN_W wide, counts down.
  - divider DIV_W wide, counts 0..D-1.
  - frame counter 4 bits.
  - gap counter 4 bits.
  - No wrap-around in any counter; terminal values trigger the transitions above.
- Outputs are registered (no combinational path from inputs to x_out or x_valid). ready is decoded from the state register.

Test Plan:
- Basic frame: pattern=8'b00000101, len=3, bit_div=1, repeat_n=0, start at cycle 0 → x_out=1,0,1 at cycles 1–3 with x_valid=1; done at cycle 4. Connected detector shows z=1 for one cycle after the third bit.
- Divider: same pattern, bit_div=3 → x_out=1 for cycles 1–3, 0 for 4–6, 1 for 7–9; done at cycle 10. bit_div=0 gives the same timing as bit_div=1.
- Repeat:
  - repeat_n=1, gap=0 → x_out=1,0,1,1,0,1 on cycles 1–6, done at 7; detector z pulses twice.
  - repeat_n=1, gap=2 → x_valid low at cycles 4–5, second frame on 6–8, done at 9.
- Edge inputs:
  - len=0 → done at cycle 1, x_valid never high.
  - len=12 with MAX_LEN=8 → 8 bits sent, pattern[7] first.
- Handshake: start pulsed at cycle 2 during a 3-bit frame → ignored, single frame only. start during the done cycle → new frame starts the next cycle.
- Abort/reset:
  - abort at cycle 2 → x_out=0, x_valid=0, ready=1 from cycle 3, no done.
  - rst_n low at cycle 2 → outputs 0 and ready=1 immediately (asynchronous). After release, a new start transmits normally.

Source files
------------

// File: rtl/serial_pass_tx.sv
// rtl/serial_pass_tx.sv - serial pattern transmitter, MSB-first, with divider, repeat, gap and abort
module serial_pass_tx #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int DIV_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [3:0]         repeat_n,
    input  logic [3:0]         gap,
    input  logic [DIV_W-1:0]   bit_div,
    output logic               ready,
    output logic               x_out,
    output logic               x_valid,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

    state_t             state_q,     state_d;
    logic [MAX_LEN-1:0] pat_q,       pat_d;
    logic [LEN_W-1:0]   len_q,       len_d;
    logic [3:0]         gap_q,       gap_d;
    logic [DIV_W-1:0]   div_q,       div_d;
    logic [LEN_W-1:0]   bit_idx_q,   bit_idx_d;
    logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
    logic [3:0]         frame_cnt_q, frame_cnt_d;
    logic [3:0]         gap_cnt_q,   gap_cnt_d;
    logic               x_out_q,     x_out_d;
    logic               x_valid_q,   x_valid_d;
    logic               done_q,      done_d;

    logic [LEN_W-1:0]   len_clamp;
    logic [DIV_W-1:0]   div_eff;
    logic               last_div_clk;
    logic               last_gap_clk;

    // Select one bit of a pattern by index; a shift keeps the index width independent of MAX_LEN.
    function automatic logic bit_at(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] idx);
        logic [MAX_LEN-1:0] s;
        s = p >> idx;
        return s[0];
    endfunction

    // Request-side normalisation: clamp the length, treat a zero divider as one clock per bit.
    always_comb begin
        len_clamp = (len > MAX_LEN_L) ? MAX_LEN_L : len;
        div_eff   = (bit_div == '0) ? DIV_ONE : bit_div;
    end

    // Terminal-count decodes for the bit divider and the inter-frame gap counter.
    always_comb begin
        last_div_clk = (div_cnt_q == (div_q - DIV_ONE));
        last_gap_clk = (gap_cnt_q == (gap_q - 4'd1));
    end

    // Next-state and next-output logic; every output is produced one clock ahead and registered.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        gap_d       = gap_q;
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        div_cnt_d   = div_cnt_q;
        frame_cnt_d = frame_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        x_out_d     = x_out_q;
        x_valid_d   = x_valid_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                x_out_d   = 1'b0;
                x_valid_d = 1'b0;
                // start wins over abort here: abort is only meaningful while busy
                if (start) begin
                    pat_d       = pattern;
                    len_d       = len_clamp;
                    gap_d       = gap;
                    div_d       = div_eff;
                    frame_cnt_d = repeat_n;
                    div_cnt_d   = '0;
                    gap_cnt_d   = '0;
                    if (len_clamp != '0) begin
                        state_d   = ST_SEND;
                        bit_idx_d = len_clamp - LEN_ONE;
                        x_out_d   = bit_at(pattern, len_clamp - LEN_ONE);
                        x_valid_d = 1'b1;
                    end else begin
                        // empty frame: nothing to send, just acknowledge completion
                        done_d = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    x_out_d     = 1'b0;
                    x_valid_d   = 1'b0;
                    bit_idx_d   = '0;
                    div_cnt_d   = '0;
                    frame_cnt_d = '0;
                    gap_cnt_d   = '0;
                end else if (!last_div_clk) begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end else begin
                    div_cnt_d = '0;
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - LEN_ONE;
                        x_out_d   = bit_at(pat_q, bit_idx_q - LEN_ONE);
                        x_valid_d = 1'b1;
                    end else if (frame_cnt_q != '0) begin
                        frame_cnt_d = frame_cnt_q - 4'd1;
                        bit_idx_d   = len_q - LEN_ONE;
                        if (gap_q != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                            x_out_d   = 1'b0;
                            x_valid_d = 1'b0;
                        end else begin
                            // back-to-back frame: no idle cycle between bit 0 and the next MSB
                            x_out_d   = bit_at(pat_q, len_q - LEN_ONE);
                            x_valid_d = 1'b1;
                        end
                    end else begin
                        state_d   = ST_IDLE;
                        x_out_d   = 1'b0;
                        x_valid_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                x_out_d   = 1'b0;
                x_valid_d = 1'b0;
                if (abort) begin
                    state_d     = ST_IDLE;
                    bit_idx_d   = '0;
                    div_cnt_d   = '0;
                    frame_cnt_d = '0;
                    gap_cnt_d   = '0;
                end else if (last_gap_clk) begin
                    state_d   = ST_SEND;
                    gap_cnt_d = '0;
                    div_cnt_d = '0;
                    bit_idx_d = len_q - LEN_ONE;
                    x_out_d   = bit_at(pat_q, len_q - LEN_ONE);
                    x_valid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                x_out_d   = 1'b0;
                x_valid_d = 1'b0;
            end
        endcase
    end

    // State, captured request and counters; asynchronous reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            div_q       <= '0;
            bit_idx_q   <= '0;
            div_cnt_q   <= '0;
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
            x_out_q     <= 1'b0;
            x_valid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            div_q       <= div_d;
            bit_idx_q   <= bit_idx_d;
            div_cnt_q   <= div_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            x_out_q     <= x_out_d;
            x_valid_q   <= x_valid_d;
            done_q      <= done_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;

endmodule
